// File: rtl/iob_axis_rr_arbiter.sv
// Packet-level round-robin arbiter merging N_INPUTS AXI-Stream sources into one stream.
// A grant is held until the accepted tlast beat, so packets never interleave. An optional
// per-grant beat limit (max_len_i, 0 = unlimited) forces tlast so no source can starve the rest.
//
// Ports:
//   clk_i, cke_i, arst_n_i, rst_i  clock, clock enable, async active-low reset, sync soft reset
//   en_i                           gate for new grants (a packet in flight always completes)
//   max_len_i                      beats per grant before tlast is forced, 0 = unlimited
//   in_t*_i / in_tready_o          per-source streams, source k data at [k*TDATA_W +: TDATA_W]
//   out_t*_o / out_tready_i        merged stream
//   grant_o, busy_o, beat_cnt_o    one-hot grant, GRANT-state flag, beats in current grant
//
// Optional feature (macro IOB_AXIS_RR_ARBITER_STATS_EN):
//   pkt_cnt_o    per-source count of ended grants, source k at [k*LEN_W +: LEN_W]
//   forced_cnt_o count of grants ended by the beat limit
module iob_axis_rr_arbiter #(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned TDATA_W  = 8,
  parameter int unsigned LEN_W    = 16
) (
  input  logic                          clk_i,
  input  logic                          cke_i,
  input  logic                          arst_n_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [LEN_W-1:0]              max_len_i,
  input  logic [N_INPUTS-1:0]           in_tvalid_i,
  input  logic [N_INPUTS*TDATA_W-1:0]   in_tdata_i,
  input  logic [N_INPUTS-1:0]           in_tlast_i,
  output logic [N_INPUTS-1:0]           in_tready_o,
  output logic                          out_tvalid_o,
  output logic [TDATA_W-1:0]            out_tdata_o,
  output logic                          out_tlast_o,
  input  logic                          out_tready_i,
  output logic [N_INPUTS-1:0]           grant_o,
  output logic                          busy_o,
  output logic [LEN_W-1:0]              beat_cnt_o
`ifdef IOB_AXIS_RR_ARBITER_STATS_EN
  ,
  output logic [N_INPUTS*LEN_W-1:0]     pkt_cnt_o,
  output logic [LEN_W-1:0]              forced_cnt_o
`endif
);

  localparam int unsigned IdxW = $clog2(N_INPUTS);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e                state_q, state_d;
  logic [N_INPUTS-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]       gidx_q, gidx_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [LEN_W-1:0]      beat_cnt_q, beat_cnt_d;

  logic                  busy;
  logic                  found;
  logic [IdxW-1:0]       win_idx;
  logic                  limit_hit;
  logic                  beat;
  logic                  pkt_end;

  // Round-robin search starting at ptr_q; the result is only used to register the grant.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int i = 0; i < int'(N_INPUTS); i++) begin
      int j;
      j = int'(ptr_q) + i;
      if (j >= int'(N_INPUTS)) j = j - int'(N_INPUTS);
      if (!found && in_tvalid_i[j]) begin
        found   = 1'b1;
        win_idx = IdxW'(j);
      end
    end
  end

  assign busy      = (state_q == StGrant);
  assign limit_hit = (max_len_i != '0) && (beat_cnt_q == max_len_i - LEN_W'(1));

  // Pure forwarding from the granted source; nothing toward a source looks at its own tvalid.
  assign out_tvalid_o = busy & in_tvalid_i[gidx_q];
  assign out_tdata_o  = busy ? in_tdata_i[gidx_q*TDATA_W +: TDATA_W] : '0;
  assign out_tlast_o  = out_tvalid_o & (in_tlast_i[gidx_q] | limit_hit);
  assign in_tready_o  = busy ? (grant_q & {N_INPUTS{out_tready_i}}) : '0;

  assign beat    = out_tvalid_o & out_tready_i;
  assign pkt_end = beat & out_tlast_o;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (en_i && found) begin
          state_d          = StGrant;
          gidx_d           = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          beat_cnt_d       = '0;
        end
      end
      StGrant: begin
        if (beat) beat_cnt_d = beat_cnt_q + LEN_W'(1);
        if (pkt_end) begin
          state_d = StIdle;
          grant_d = '0;
          ptr_d   = (gidx_q == IdxW'(N_INPUTS - 1)) ? '0 : gidx_q + IdxW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      gidx_q     <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        state_q    <= StIdle;
        grant_q    <= '0;
        gidx_q     <= '0;
        ptr_q      <= '0;
        beat_cnt_q <= '0;
      end else begin
        state_q    <= state_d;
        grant_q    <= grant_d;
        gidx_q     <= gidx_d;
        ptr_q      <= ptr_d;
        beat_cnt_q <= beat_cnt_d;
      end
    end
  end

  assign grant_o    = grant_q;
  assign busy_o     = busy;
  assign beat_cnt_o = beat_cnt_q;

`ifdef IOB_AXIS_RR_ARBITER_STATS_EN
  logic [N_INPUTS-1:0][LEN_W-1:0] pkt_cnt_q;
  logic [LEN_W-1:0]               forced_cnt_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pkt_cnt_q    <= '0;
      forced_cnt_q <= '0;
    end else if (cke_i) begin
      if (rst_i) begin
        pkt_cnt_q    <= '0;
        forced_cnt_q <= '0;
      end else if (pkt_end) begin
        pkt_cnt_q[gidx_q] <= pkt_cnt_q[gidx_q] + LEN_W'(1);
        if (limit_hit) forced_cnt_q <= forced_cnt_q + LEN_W'(1);
      end
    end
  end

  assign pkt_cnt_o    = pkt_cnt_q;
  assign forced_cnt_o = forced_cnt_q;
`endif

endmodule

// File: tb/tb_iob_axis_rr_arbiter.sv
// Scoreboard bench for iob_axis_rr_arbiter: per-source expected beat queues are filled when
// packets are generated; a monitor process pops them on every accepted output beat and checks
// grant order, forwarding, forced tlast and beat counting against a rule-level model.
module tb_iob_axis_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LW = 16;

  logic              clk = 1'b0;
  logic              cke, arst_n, rst, en;
  logic [LW-1:0]     max_len;
  logic [N-1:0]      in_tvalid, in_tlast, in_tready;
  logic [N*DW-1:0]   in_tdata;
  logic              out_tvalid, out_tlast, out_tready;
  logic [DW-1:0]     out_tdata;
  logic [N-1:0]      grant;
  logic              busy;
  logic [LW-1:0]     beat_cnt;
`ifdef IOB_AXIS_RR_ARBITER_STATS_EN
  logic [N*LW-1:0]   pkt_cnt;
  logic [LW-1:0]     forced_cnt;
`endif

  iob_axis_rr_arbiter #(.N_INPUTS(N), .TDATA_W(DW), .LEN_W(LW)) dut (
    .clk_i        (clk),
    .cke_i        (cke),
    .arst_n_i     (arst_n),
    .rst_i        (rst),
    .en_i         (en),
    .max_len_i    (max_len),
    .in_tvalid_i  (in_tvalid),
    .in_tdata_i   (in_tdata),
    .in_tlast_i   (in_tlast),
    .in_tready_o  (in_tready),
    .out_tvalid_o (out_tvalid),
    .out_tdata_o  (out_tdata),
    .out_tlast_o  (out_tlast),
    .out_tready_i (out_tready),
    .grant_o      (grant),
    .busy_o       (busy),
    .beat_cnt_o   (beat_cnt)
`ifdef IOB_AXIS_RR_ARBITER_STATS_EN
    ,
    .pkt_cnt_o    (pkt_cnt),
    .forced_cnt_o (forced_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    bit            l;
  } beat_t;

  beat_t stim_q [N][$];
  beat_t exp_q  [N][$];

  int n_cmp = 0;
  int n_bad = 0;
  int vprob = 0, rprob = 0, ckeprob = 0, rstprob = 0;
  bit mon_en = 0;
  bit drv_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input int k, input logic [DW-1:0] d, input bit l);
    beat_t b;
    b.d = d;
    b.l = l;
    stim_q[k].push_back(b);
    exp_q[k].push_back(b);
  endtask

  task automatic push_pkt(input int k, input int len);
    for (int i = 0; i < len; i++) push_beat(k, DW'($urandom), (i == len - 1));
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (stim_q[k].size() != 0) return 0;
    return 1;
  endfunction

  // Source/sink driver: drives at negedge, samples handshakes 1 time unit before posedge.
  initial begin
    logic [N-1:0] hs;
    hs = '0;
    forever begin
      @(negedge clk);
      if (drv_en) begin
        for (int k = 0; k < N; k++) if (hs[k]) void'(stim_q[k].pop_front());
        for (int k = 0; k < N; k++) begin
          if (stim_q[k].size() != 0 && int'($urandom_range(99)) < vprob) begin
            in_tvalid[k]          = 1'b1;
            in_tdata[k*DW +: DW]  = stim_q[k][0].d;
            in_tlast[k]           = stim_q[k][0].l;
          end else begin
            in_tvalid[k]          = 1'b0;
            in_tdata[k*DW +: DW]  = DW'($urandom);
            in_tlast[k]           = 1'($urandom);
          end
        end
        cke        = !(int'($urandom_range(99)) < ckeprob);
        out_tready = cke && (int'($urandom_range(99)) < rprob);
        rst        = int'($urandom_range(999)) < rstprob;
        #4;
        hs = in_tvalid & in_tready;
      end
    end
  end

  // Monitor with rule-level model of grant, pointer and per-grant beat count.
  initial begin
    logic [N-1:0]  m_grant, p_valid, oh;
    int            m_ptr, m_cnt, g, j;
    bit            have_prev, p_en, p_cke, p_rst, p_beat, p_last, e_valid, e_last;
    beat_t         e;
    m_grant = '0; m_ptr = 0; m_cnt = 0; have_prev = 0;
    forever begin
      @(negedge clk);
      #4;
      if (mon_en) begin
        if (have_prev) begin
          if (p_cke && !p_rst && m_grant != '0 && p_beat) m_cnt++;
          if (p_rst && p_cke) begin
            m_grant = '0; m_ptr = 0; m_cnt = 0;
          end else if (!p_cke) begin
            // everything holds
          end else if (m_grant == '0) begin
            if (p_en && |p_valid) begin
              oh = '0;
              for (int i = N - 1; i >= 0; i--) begin
                j = (m_ptr + i) % N;
                if (p_valid[j]) begin
                  oh = '0;
                  oh[j] = 1'b1;
                end
              end
              m_grant = oh;
              m_cnt   = 0;
            end
          end else if (p_beat && p_last) begin
            for (int k = 0; k < N; k++) if (m_grant[k]) m_ptr = (k + 1) % N;
            m_grant = '0;
          end
        end
        have_prev = 1;
        chk("grant", 32'(grant), 32'(m_grant));
        chk("busy", 32'(busy), 32'(m_grant != '0));
        chk("in_tready", 32'(in_tready), 32'(m_grant & {N{out_tready}}));
        g = 0;
        for (int k = 0; k < N; k++) if (m_grant[k]) g = k;
        e_valid = (m_grant != '0) && in_tvalid[g];
        chk("out_tvalid", 32'(out_tvalid), 32'(e_valid));
        p_beat = 0; p_last = 0;
        if (m_grant == '0) begin
          chk("idle_tdata", 32'(out_tdata), 32'h0);
        end else begin
          chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt % 65536));
          if (e_valid) begin
            if (exp_q[g].size() == 0) begin
              chk("exp_underflow", 32'(exp_q[g].size()), 32'h1);
            end else begin
              e = exp_q[g][0];
              e_last = e.l || (max_len != 0 && m_cnt + 1 == int'(max_len));
              chk("out_tdata", 32'(out_tdata), 32'(e.d));
              chk("out_tlast", 32'(out_tlast), 32'(e_last));
              if (out_tready) begin
                void'(exp_q[g].pop_front());
                p_beat = 1;
                p_last = e_last;
              end
            end
          end
        end
        p_valid = in_tvalid; p_en = en; p_cke = cke; p_rst = rst;
      end
    end
  end

  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    int guard;
    cke = 1; arst_n = 0; rst = 0; en = 0; max_len = '0;
    in_tvalid = '0; in_tdata = '0; in_tlast = '0; out_tready = 0;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'h0);
    chk("rst_out_tvalid", 32'(out_tvalid), 32'h0);
    chk("rst_out_tlast", 32'(out_tlast), 32'h0);
    chk("rst_in_tready", 32'(in_tready), 32'h0);
    chk("rst_out_tdata", 32'(out_tdata), 32'h0);
    @(negedge clk);
    arst_n = 1; en = 1; mon_en = 1; drv_en = 1;

    // Source 2 alone, 3-beat packet.
    push_beat(2, 8'hA1, 0); push_beat(2, 8'hA2, 0); push_beat(2, 8'hA3, 1);
    vprob = 100; rprob = 100;
    run(10);

    // All sources with 1-beat packets back to back.
    for (int r = 0; r < 3; r++) for (int k = 0; k < N; k++) push_pkt(k, 1);
    run(30);

    // Beat limit: long packet on source 0 while source 1 waits.
    max_len = 16'd4;
    push_pkt(0, 10);
    push_pkt(1, 2);
    run(40);

    // max_len = 1 forces every beat last.
    max_len = 16'd1;
    push_pkt(3, 3); push_pkt(1, 2);
    run(20);

    // Randomized traffic with backpressure, en toggling, cke gaps and soft resets.
    for (int it = 0; it < 6; it++) begin
      case (it % 3)
        0: max_len = 16'd0;
        1: max_len = 16'd3;
        default: max_len = 16'd1;
      endcase
      for (int k = 0; k < N; k++) repeat (3) push_pkt(k, 1 + int'($urandom_range(6)));
      vprob = 70; rprob = 50; ckeprob = 5; rstprob = 15;
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        if ($urandom_range(9) == 0) en = ~en;
      end
    end

    // Drain everything with a bounded wait.
    en = 1; vprob = 100; rprob = 100; ckeprob = 0; rstprob = 0;
    guard = 0;
    while (!all_empty() && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_timeout", 32'(all_empty()), 32'h1);
    run(5);
    for (int k = 0; k < N; k++) chk("exp_left", 32'(exp_q[k].size()), 32'h0);
    mon_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/iob_axis_rr_arbiter.md
Name: iob_axis_rr_arbiter

Overview:
- Packet-level round-robin arbiter that merges N AXI-Stream sources into one stream.
- Typically drives the axis input of the AXI-Stream input peripheral, so several producers can share one CSR/FIFO datapath.
- Grants are held for a whole packet (until tlast), so packets never interleave.
- An optional per-packet beat limit prevents one source from starving the others; when the limit is hit, the block forces tlast.

Parameters:
- N_INPUTS, 4, number of requesting streams (≥2).
- TDATA_W, 8, stream data width.
- LEN_W, 16, width of the beat counter and of the max-length input.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- cke_i  in  1  clock enable; when low, all registers hold.
- arst_n_i  in  1  asynchronous reset, active-low.
- rst_i  in  1  synchronous soft reset, active-high.
- en_i  in  1  when low, no new grants are issued; a packet in flight still completes.
- max_len_i  in  LEN_W  maximum beats per grant; 0 means unlimited.
- in_tvalid_i  in  N_INPUTS  per-source valid.
- in_tdata_i  in  N_INPUTS*TDATA_W  source k occupies bits [k*TDATA_W+:TDATA_W].
- in_tlast_i  in  N_INPUTS  per-source last.
- in_tready_o  out  N_INPUTS  per-source ready.
- out_tvalid_o  out  1  merged valid.
- out_tdata_o  out  TDATA_W  merged data.
- out_tlast_o  out  1  merged last (includes forced last).
- out_tready_i  in  1  downstream ready.
- grant_o  out  N_INPUTS  one-hot current grant; all zero in IDLE.
- busy_o  out  1  high in the GRANT state.
- beat_cnt_o  out  LEN_W  beats accepted in the current grant.

Behaviour:
- Reset (arst_n_i=0, or rst_i=1 with cke_i=1) gives:
  - state=IDLE, grant_o=0, priority pointer ptr=0, beat_cnt_o=0, busy_o=0;
  - out_tvalid_o=0, out_tlast_o=0, in_tready_o=0.
  - out_tdata_o is 0 whenever no grant is active.
- FSM state IDLE:
  - If en_i=1 and any in_tvalid_i is set, select the first requester k scanning ptr, ptr+1, … modulo N_INPUTS.
  - Register grant_o=onehot(k), clear beat_cnt_o and go to GRANT.
  - Arbitration costs exactly 1 cycle: first beat at the earliest in the cycle after the request is seen.
  - If there are no requests or en_i=0, stay in IDLE.
- FSM state GRANT (source g):
  - Combinational forwarding:
    - out_tvalid_o=in_tvalid_i[g];
    - out_tdata_o=in_tdata_i[g];
    - in_tready_o[g]=out_tready_i;
    - in_tready_o for every other source = 0.
  - A beat is accepted when out_tvalid_o & out_tready_i; each accepted beat increments beat_cnt_o.
  - limit_hit = (max_len_i != 0) & (beat_cnt_o == max_len_i-1).
  - out_tlast_o = in_tlast_i[g] | limit_hit, while out_tvalid_o is high.
  - An accepted beat with out_tlast_o=1 ends the grant: next cycle state=IDLE, grant_o=0, ptr=(g+1) mod N_INPUTS.
  - A source that stalls (tvalid low) keeps the grant indefinitely; there is no timeout.
  - Toggling en_i does not affect GRANT.
- Width rules:
  - beat_cnt_o wraps modulo 2^LEN_W when max_len_i=0.
  - max_len_i is sampled every cycle; lowering it below the current beat_cnt_o disables the limit until wrap. This is legal but is not a tested use.
- Boundary cases:
  - Single-beat packet (tlast on the first beat): the grant lasts 1 beat and a 1-cycle bubble follows.
  - max_len_i=1: every beat is forced last.
  - Simultaneous requests from all sources resolve strictly in pointer order.
  - Soft reset mid-packet drops the grant immediately; the partial packet is not terminated with tlast.
- Ready and valid outputs toward sources never depend combinationally on an in_tvalid_i of the same source. The exception is the IDLE→GRANT decision, which is registered.

Optional Feature:
- Macro: IOB_AXIS_RR_ARBITER_STATS_EN.
- When defined, the block adds:
  - output pkt_cnt_o, width N_INPUTS*LEN_W, with source k at [k*LEN_W+:LEN_W];
  - a wrapping counter per source that increments when that source's grant ends (natural or forced last);
  - output forced_cnt_o, width LEN_W, counting grants ended by limit_hit only.
- All counters clear on reset or rst_i.
- When not defined, these ports and registers do not exist and the remaining behaviour is identical.

Test Plan:
- Reset with arst_n_i=0, then release: all outputs 0, grant_o=4'b0000. Source 2 presents a 3-beat packet (tdata 0xA1,0xA2,0xA3) with out_tready_i=1 → grant_o=4'b0100 one cycle later, then 3 beats out, tlast on 0xA3, then IDLE.
- All 4 sources hold 1-beat packets continuously, max_len_i=0 → grant order 0,1,2,3,0; each grant 1 beat followed by 1 idle cycle.
- Source 0 sends a 10-beat packet with max_len_i=4 → out_tlast_o forced on beats 4 and 8; source 0 loses the grant after beat 4 while source 1 is waiting; with STATS_EN, forced_cnt_o counts forced grants.
- Backpressure: out_tready_i toggles every other cycle during a 5-beat packet → no beat lost or duplicated; in_tready_o of the non-granted sources stays 0; beat_cnt_o reaches 5.
- en_i dropped after beat 2 of a 4-beat packet → packet completes; no new grant while en_i=0 even with pending requests; the grant resumes 1 cycle after en_i=1.
- rst_i pulsed mid-packet on source 3 → next cycle grant_o=0, beat_cnt_o=0, ptr=0; a pending source 0 wins next.
